// File: rtl/mux_pkg.sv
// Shared definitions for the calculator datapath word multiplexer.
// Holds the default data width, the select encodings and the default word type.
package mux_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage : mux_pkg

// File: rtl/mux2_comb.sv
// Pure combinational 2:1 word select: y = s ? b : a, bit for bit over WIDTH.
// No state and no arithmetic; the registered wrapper lives in the top module.
module mux2_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  // Steer b when the select encodes operand B, otherwise a.
  always_comb begin
    y = a;
    if (s == SEL_B) begin
      y = b;
    end else begin
      y = a;
    end
  end

endmodule : mux2_comb

// File: rtl/mux4bits_2entradas.sv
// Registered 2:1 word multiplexer for the calculator datapath.
// Selects A (S=0) or B (S=1), registers the result with a valid flag, the
// select used and an A==B status flag. All outputs come from flops.
// Optional feature: define MUX4B_PARITY_EN to add parity_o, the registered
// XOR-reduction of the selected word, captured and held like Y.
module mux4bits_2entradas
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             S,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Y,
  output logic             out_valid,
  output logic             sel_o,
`ifdef MUX4B_PARITY_EN
  output logic             same_o,
  output logic             parity_o
`else
  output logic             same_o
`endif
);

  // Even/odd parity of a word: 1 when an odd number of bits are set.
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] comb_s;
  logic             same_s;

  logic [WIDTH-1:0] y_r;
  logic             out_valid_r;
  logic             sel_r;
  logic             same_r;

  mux2_comb #(
    .WIDTH (WIDTH)
  ) u_mux2_comb (
    .a (A),
    .b (B),
    .s (S),
    .y (comb_s)
  );

  // Equality status of the two operands presented this cycle.
  always_comb begin
    same_s = 1'b0;
    if (A == B) begin
      same_s = 1'b1;
    end else begin
      same_s = 1'b0;
    end
  end

  // Output stage: capture on in_valid, hold data otherwise; valid is a one-cycle echo of in_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_r         <= {WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      sel_r       <= 1'b0;
      same_r      <= 1'b0;
    end else if (in_valid) begin
      y_r         <= comb_s;
      out_valid_r <= 1'b1;
      sel_r       <= S;
      same_r      <= same_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

`ifdef MUX4B_PARITY_EN
  logic parity_r;

  // Parity of the selected word, following the same capture/hold rule as Y.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_r <= 1'b0;
    end else if (in_valid) begin
      parity_r <= parity_of(comb_s);
    end else begin
      parity_r <= parity_r;
    end
  end

  assign parity_o = parity_r;
`endif

  assign Y         = y_r;
  assign out_valid = out_valid_r;
  assign sel_o     = sel_r;
  assign same_o    = same_r;

endmodule : mux4bits_2entradas

// File: tb/tb_mux4bits_2entradas.sv
// Self-checking bench for mux4bits_2entradas: directed steps from the test
// plan followed by random traffic, compared against a behavioural model.
module tb_mux4bits_2entradas;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         S;
  logic         in_valid;
  logic [W-1:0] Y;
  logic         out_valid;
  logic         sel_o;
  logic         same_o;
`ifdef MUX4B_PARITY_EN
  logic         parity_o;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state: what the outputs must show after the last edge.
  int exp_y, exp_v, exp_sel, exp_same, exp_par;

  mux4bits_2entradas #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .S         (S),
    .in_valid  (in_valid),
    .Y         (Y),
    .out_valid (out_valid),
    .sel_o     (sel_o),
`ifdef MUX4B_PARITY_EN
    .same_o    (same_o),
    .parity_o  (parity_o)
`else
    .same_o    (same_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // S must be a clean 0/1 whenever the inputs are qualified.
  always @(posedge clk) begin
    if (!rst && in_valid) begin
      assert (S === 1'b0 || S === 1'b1)
      else $error("FAIL s_legal observed=%b required=0_or_1", S);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".Y"},         {28'd0, Y},       exp_y);
    check({tag, ".out_valid"}, {31'd0, out_valid}, exp_v);
    check({tag, ".sel_o"},     {31'd0, sel_o},   exp_sel);
    check({tag, ".same_o"},    {31'd0, same_o},  exp_same);
`ifdef MUX4B_PARITY_EN
    check({tag, ".parity_o"},  {31'd0, parity_o}, exp_par);
`endif
  endtask

  task automatic model_reset();
    exp_y = 0; exp_v = 0; exp_sel = 0; exp_same = 0; exp_par = 0;
  endtask

  // Called from a negedge: drive, let one rising edge pass, update model, check at next negedge.
  task automatic step(input int a, input int b, input int s, input int v, input string tag);
    int chosen;
    A = a[W-1:0]; B = b[W-1:0]; S = s[0]; in_valid = v[0];
    @(posedge clk);
    if (v != 0) begin
      chosen   = (s != 0) ? b : a;
      exp_y    = chosen;
      exp_sel  = s;
      exp_same = (a == b) ? 1 : 0;
      exp_par  = $countones(chosen[W-1:0]) % 2;
      exp_v    = 1;
    end else begin
      exp_v    = 0;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; S = 1'b0; in_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;

    // First capture after reset.
    step(0, 5, 0, 1, "first");
    // Back-to-back captures; out_valid checked 1 on each.
    step(5, 7, 1, 1, "b2b_sel_b");
    step(14, 15, 0, 1, "b2b_sel_a");
    step(14, 15, 1, 1, "b2b_y15");
    // Hold with toggling inputs.
    step(1, 2, 0, 0, "hold1");
    step(6, 9, 1, 0, "hold2");
    step(3, 3, 0, 0, "hold3");
    // Equal operands.
    step(9, 9, 1, 1, "equal");
    // Async reset between edges while Y=14 and out_valid=1.
    step(14, 3, 0, 1, "pre_rst");
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    step(3, 12, 0, 1, "post_rst");
    // Parity patterns.
    step(7, 0, 0, 1, "par_odd");
    step(0, 5, 1, 1, "par_even");

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      step($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
           ($urandom_range(0, 3) != 0) ? 1 : 0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mux4bits_2entradas

// File: doc/mux4bits_2entradas.md
Name: mux4bits_2entradas

Overview:
Registered 2:1 word multiplexer: selects operand A or B by select S and presents the result one clock later with a valid flag. Used in the ARM calculator datapath to steer 4-bit operands and results between functional units. The core selection is a pure combinational mux; the block adds an output register stage, valid tracking and an equality status flag.

Parameters:
WIDTH, 4, data width of A, B and Y (minimum 1).

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
A  input  WIDTH  operand selected when S=0
B  input  WIDTH  operand selected when S=1
S  input  1  select: 0 -> A, 1 -> B
in_valid  input  1  A/B/S qualify this cycle
Y  output  WIDTH  registered selected operand
out_valid  output  1  Y updated on the last rising edge
sel_o  output  1  registered copy of S used for the current Y
same_o  output  1  registered flag, A == B at capture time

Behaviour:
- Reset (rst=1, asynchronous assert; release is sampled on the next clk edge): Y=0, out_valid=0, sel_o=0, same_o=0. The parity output (optional feature) also resets to 0.
- Selection: comb = S ? B : A, bitwise over the full WIDTH with no arithmetic and no truncation.
- Capture: on a rising clk with rst=0 and in_valid=1: Y<=comb, sel_o<=S, same_o<=(A==B), out_valid<=1.
- Hold: on a rising clk with in_valid=0: Y, sel_o and same_o keep their values; out_valid<=0.
- Latency: exactly 1 cycle from an in_valid sample to Y/out_valid.
- Throughput: one result per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- No backpressure: there is no ready signal, and the downstream stage must accept the result whenever out_valid=1.
- Reset mid-operation: an in-flight capture is discarded; all outputs go to reset values immediately, without waiting for clk.
- A==B with either S value: Y equals the shared value and same_o=1.
- S unknown or X is not a legal input. A bench assertion flags S not in {0,1} whenever in_valid=1.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

Optional Feature:
Macro MUX4B_PARITY_EN.
- Defined: adds output port parity_o (1 bit) = registered XOR-reduction of comb. It is captured under the same in_valid rule as Y, held when in_valid=0, and reset to 0.
- Not defined: the port and its flop are absent, and all other behaviour is identical.

Decomposition:
- Shared package mux_pkg:
  - constant DEFAULT_WIDTH=4
  - constants SEL_A=1'b0 and SEL_B=1'b1
  - typedef word_t = logic [DEFAULT_WIDTH-1:0]
- One natural sub-module, mux2_comb: parameterised WIDTH, pure combinational 2:1 select (a, b, s -> y). The top module instantiates it and owns the registers, valid logic, equality compare and optional parity.

Test Plan:
- Reset, then A=0, B=5, S=0, in_valid=1 for 1 cycle -> next cycle Y=0, sel_o=0, same_o=0, out_valid=1.
- A=5, B=7, S=1, in_valid=1 -> Y=7, sel_o=1. Then A=14, B=15, S=0 -> Y=14. Then A=14, B=15, S=1 -> Y=15. Drive these back-to-back and check out_valid stays 1 throughout.
- Capture Y=15, then in_valid=0 for 3 cycles while A/B/S toggle -> Y stays 15, out_valid=0 on each of those cycles.
- A=9, B=9, S=1, in_valid=1 -> Y=9, same_o=1.
- Assert rst asynchronously between edges while out_valid=1 and Y=14 -> Y=0 and out_valid=0 immediately. After release, the first in_valid (A=3, S=0) gives Y=3 one cycle later.
- With MUX4B_PARITY_EN defined: A=4'b0111, S=0 -> parity_o=1. B=4'b0101, S=1 -> parity_o=0.
